// File: rtl/io_request_encoder_pkg.sv
// Shared widths, address constants, FSM states and helpers for the I/O request encoder.
package io_request_encoder_pkg;

    localparam int unsigned N_DEV  = 17;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned IDX_W  = 5;

    // Last decoded I/O slot; the RAM window starts right after it.
    localparam logic [ADDR_W-1:0] IO_LAST_ADDR = 16'h0010;
    localparam logic [ADDR_W-1:0] RAM_BASE     = 16'h0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Successor of a device index, wrapping from the last I/O slot back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IO_LAST_ADDR[IDX_W-1:0]) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/io_request_encoder_if.sv
// Request/grant bus between the I/O slots, the CPU and the encoder.
interface io_request_encoder_if;
    import io_request_encoder_pkg::*;

    logic [N_DEV-1:0]  REQ;
    logic              ACK;
    logic              OVR_CLR;
    logic [ADDR_W-1:0] ADDR;
    logic              VALID;
    logic [N_DEV-1:0]  PENDING;
    logic              OVERRUN;

    // Requesters and CPU side.
    modport master (
        output REQ, ACK, OVR_CLR,
        input  ADDR, VALID, PENDING, OVERRUN
    );

    // Encoder side.
    modport slave (
        input  REQ, ACK, OVR_CLR,
        output ADDR, VALID, PENDING, OVERRUN
    );

endinterface

// File: rtl/io_request_encoder_rr_arbiter.sv
// Combinational round-robin pick over the pending vector, starting at ptr.
module rr_arbiter
    import io_request_encoder_pkg::*;
(
    input  logic [N_DEV-1:0] pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    // Walk all slots from ptr upward modulo N_DEV; the first set bit wins.
    always_comb begin
        logic [SUM_W-1:0] pos;
        pos   = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned k = 0; k < N_DEV; k++) begin
            pos = SUM_W'(ptr) + SUM_W'(k);
            if (pos >= SUM_W'(N_DEV)) begin
                pos = pos - SUM_W'(N_DEV);
            end
            if (!any_c && pending[pos[IDX_W-1:0]]) begin
                any_c = 1'b1;
                idx_c = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/io_request_encoder.sv
// Collects I/O device requests, arbitrates round-robin and presents the
// winner as a zero-extended bus address with a valid/ack handshake.
module io_request_encoder
    import io_request_encoder_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    io_request_encoder_if.slave  bus
);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr_q;
    logic             valid_q;
    logic             overrun_q;
    logic [N_DEV-1:0] pending_q;

    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic             ack_clr;
    logic [N_DEV-1:0] clr_mask;
    logic [N_DEV-1:0] pending_nxt;
    logic [N_DEV-1:0] ovr_hits;

    rr_arbiter u_arb (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx_c   (win_idx),
        .any_c   (win_any)
    );

    // ACK only retires a grant while one is being presented.
    assign ack_clr  = (state_q == BUSY) && bus.ACK;
    assign clr_mask = ack_clr ? (N_DEV'(1) << idx_q) : '0;

    // A fresh request on the bit being retired keeps it pending.
    assign pending_nxt = (pending_q & ~clr_mask) | bus.REQ;

    // Re-request of a bit that is still owed service and not retiring now.
    assign ovr_hits = bus.REQ & pending_q & ~clr_mask;

    // Pending vector, sticky overrun and the grant FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_nxt;

            if (|ovr_hits) begin
                overrun_q <= 1'b1;
            end else if (bus.OVR_CLR) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.ACK) begin
                        ptr_q   <= next_idx(idx_q);
                        valid_q <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ADDR    = ADDR_W'(idx_q);
    assign bus.VALID   = valid_q;
    assign bus.PENDING = pending_q;
    assign bus.OVERRUN = overrun_q;

endmodule

// File: tb/tb_io_request_encoder.sv
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_io_request_encoder;
    import io_request_encoder_pkg::*;

    localparam int NDEV = 17;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    io_request_encoder_if bus ();

    io_request_encoder dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending set, round-robin pointer, presented grant, and the number
    // of edges that must still pass before a new grant may be issued.
    bit m_pend[NDEV];
    int m_ptr;
    int m_addr;
    int m_cool;
    bit m_valid;
    bit m_ovr;

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_ptr   = 0;
        m_addr  = 0;
        m_cool  = 0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endfunction

    function automatic logic [NDEV-1:0] model_pend_vec();
        logic [NDEV-1:0] v;
        for (int i = 0; i < NDEV; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic void model_step();
        bit              old[NDEV];
        logic [NDEV-1:0] req;
        int              clr;
        bit              hit;
        bit              found;
        req   = bus.REQ;
        old   = m_pend;
        clr   = (m_valid && bus.ACK) ? m_addr : -1;
        hit   = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (req[i] && old[i] && i != clr) hit = 1'b1;
            m_pend[i] = (old[i] && i != clr) || req[i];
        end
        if (hit) m_ovr = 1'b1;
        else if (bus.OVR_CLR) m_ovr = 1'b0;
        if (m_valid && bus.ACK) begin
            m_valid = 1'b0;
            m_ptr   = (m_addr + 1) % NDEV;
            m_cool  = 1;
        end else if (!m_valid && m_cool > 0) begin
            m_cool = m_cool - 1;
        end else if (!m_valid) begin
            found = 1'b0;
            for (int k = 0; k < NDEV; k++) begin
                if (!found && old[(m_ptr + k) % NDEV]) begin
                    found   = 1'b1;
                    m_addr  = (m_ptr + k) % NDEV;
                    m_valid = 1'b1;
                end
            end
        end
    endfunction

    // One clock: model follows the edge, caller resumes on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.REQ     = '0;
        bus.ACK     = 1'b0;
        bus.OVR_CLR = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.ADDR !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", bus.ADDR); end
        n_checks++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.VALID); end
        n_checks++; if (bus.PENDING !== 17'h0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", bus.PENDING); end
        n_checks++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.OVERRUN); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [NDEV-1:0] onehot;
        logic [NDEV-1:0] exp_bit;
        exp_bit = 17'h00020;
        bus.REQ = exp_bit;
        tick();
        bus.REQ = '0;
        n_checks++; if (bus.PENDING !== exp_bit) begin n_fail++; $display("FAIL single_pending: got %0h expected %0h", bus.PENDING, exp_bit); end
        n_checks++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", bus.VALID); end
        tick();
        n_checks++; if (bus.VALID !== 1'b1 || bus.ADDR !== 16'h0005) begin n_fail++; $display("FAIL single_grant: got valid=%b addr=%0h expected valid=1 addr=5", bus.VALID, bus.ADDR); end
        onehot = NDEV'(1) << bus.ADDR[4:0];
        n_checks++; if (onehot !== exp_bit || bus.ADDR[15:5] !== 11'h0) begin n_fail++; $display("FAIL single_decode: got %0h expected %0h", onehot, exp_bit); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        n_checks++; if (bus.VALID !== 1'b0 || bus.PENDING !== 17'h0) begin n_fail++; $display("FAIL single_ack: got valid=%b pending=%0h expected 0/0", bus.VALID, bus.PENDING); end
        tick();
        tick();
    endtask

    task automatic test_rr_wrap();
        int exp_seq[5];
        bit ok;
        exp_seq = '{0, 3, 16, 0, 16};
        apply_reset();
        bus.REQ = 17'h10009;
        tick();
        bus.REQ = '0;
        for (int g = 0; g < 5; g++) begin
            if (g == 3) begin
                bus.REQ = 17'h10001;
                tick();
                bus.REQ = '0;
            end
            wait_valid(ok);
            n_checks++;
            if (!ok || bus.ADDR !== 16'(exp_seq[g])) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got valid=%b addr=%0h expected addr=%0h", g, bus.VALID, bus.ADDR, exp_seq[g]);
            end
            bus.ACK = 1'b1;
            tick();
            bus.ACK = 1'b0;
        end
    endtask

    task automatic test_hold();
        bit ok;
        bus.REQ = 17'h00080;
        tick();
        bus.REQ = '0;
        wait_valid(ok);
        n_checks++; if (!ok || bus.ADDR !== 16'h0007) begin n_fail++; $display("FAIL hold_grant: got valid=%b addr=%0h expected addr=7", bus.VALID, bus.ADDR); end
        for (int c = 0; c < 10; c++) begin
            bus.REQ = (c == 0) ? 17'h00004 : 17'h0;
            tick();
            n_checks++;
            if (bus.VALID !== 1'b1 || bus.ADDR !== 16'h0007) begin
                n_fail++;
                $display("FAIL hold_stable%0d: got valid=%b addr=%0h expected 1/7", c, bus.VALID, bus.ADDR);
            end
        end
        bus.REQ = '0;
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        n_checks++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL hold_ack_low: got %b expected 0", bus.VALID); end
        tick();
        n_checks++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL hold_gap_low: got %b expected 0", bus.VALID); end
        tick();
        n_checks++; if (bus.VALID !== 1'b1 || bus.ADDR !== 16'h0002) begin n_fail++; $display("FAIL hold_next: got valid=%b addr=%0h expected 1/2", bus.VALID, bus.ADDR); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overrun();
        bit ok;
        n_checks++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ovr_initial: got %b expected 0", bus.OVERRUN); end
        bus.REQ = 17'h00010;
        tick();
        tick();
        bus.REQ = '0;
        n_checks++; if (bus.OVERRUN !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", bus.OVERRUN); end
        bus.OVR_CLR = 1'b1;
        tick();
        bus.OVR_CLR = 1'b0;
        n_checks++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", bus.OVERRUN); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        tick();
        tick();
        bus.REQ = 17'h00200;
        tick();
        bus.REQ = '0;
        wait_valid(ok);
        n_checks++; if (!ok || bus.ADDR !== 16'h0009) begin n_fail++; $display("FAIL setclr_grant: got valid=%b addr=%0h expected addr=9", bus.VALID, bus.ADDR); end
        bus.ACK = 1'b1;
        bus.REQ = 17'h00200;
        tick();
        bus.ACK = 1'b0;
        bus.REQ = '0;
        n_checks++; if (bus.PENDING[9] !== 1'b1 || bus.VALID !== 1'b0) begin n_fail++; $display("FAIL setclr_pending: got pend9=%b valid=%b expected 1/0", bus.PENDING[9], bus.VALID); end
        n_checks++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL setclr_overrun: got %b expected 0", bus.OVERRUN); end
        bus.REQ     = 17'h00200;
        bus.OVR_CLR = 1'b1;
        tick();
        bus.REQ = '0;
        n_checks++; if (bus.OVERRUN !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected 1", bus.OVERRUN); end
        tick();
        bus.OVR_CLR = 1'b0;
        n_checks++; if (bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ovr_clear2: got %b expected 0", bus.OVERRUN); end
        wait_valid(ok);
        n_checks++; if (!ok || bus.ADDR !== 16'h0009) begin n_fail++; $display("FAIL setclr_regrant: got valid=%b addr=%0h expected addr=9", bus.VALID, bus.ADDR); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.REQ = 17'h01042;
        tick();
        bus.REQ = '0;
        tick();
        n_checks++; if (bus.VALID !== 1'b1 || bus.ADDR !== 16'h000C || bus.PENDING !== 17'h01042) begin n_fail++; $display("FAIL mid_busy: got valid=%b addr=%0h pend=%0h expected 1/c/1042", bus.VALID, bus.ADDR, bus.PENDING); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.VALID !== 1'b0 || bus.ADDR !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_grant: got valid=%b addr=%0h expected 0/0", bus.VALID, bus.ADDR); end
        n_checks++; if (bus.PENDING !== 17'h0 || bus.OVERRUN !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got pend=%0h ovr=%b expected 0/0", bus.PENDING, bus.OVERRUN); end
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        bus.REQ = 17'h00002;
        tick();
        bus.REQ = '0;
        n_checks++; if (bus.VALID !== 1'b0) begin n_fail++; $display("FAIL mid_after_early: got %b expected 0", bus.VALID); end
        tick();
        n_checks++; if (bus.VALID !== 1'b1 || bus.ADDR !== 16'h0001) begin n_fail++; $display("FAIL mid_after_grant: got valid=%b addr=%0h expected 1/1", bus.VALID, bus.ADDR); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_spurious_ack();
        bus.ACK = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (bus.VALID !== 1'b0 || bus.PENDING !== 17'h0) begin
                n_fail++;
                $display("FAIL spurious%0d: got valid=%b pend=%0h expected 0/0", c, bus.VALID, bus.PENDING);
            end
        end
        bus.ACK = 1'b0;
        bus.REQ = 17'h00008;
        tick();
        bus.REQ = '0;
        tick();
        n_checks++; if (bus.VALID !== 1'b1 || bus.ADDR !== 16'h0003) begin n_fail++; $display("FAIL spurious_then_grant: got valid=%b addr=%0h expected 1/3", bus.VALID, bus.ADDR); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
    endtask

    task automatic test_random();
        logic [NDEV-1:0] r;
        logic [NDEV-1:0] exp_pend;
        for (int c = 0; c < 600; c++) begin
            r = '0;
            if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 16)] = 1'b1;
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 16)] = 1'b1;
            bus.REQ     = r;
            bus.ACK     = ($urandom_range(0, 2) != 0);
            bus.OVR_CLR = ($urandom_range(0, 15) == 0);
            tick();
            exp_pend = model_pend_vec();
            n_checks++;
            if (bus.VALID !== m_valid || bus.ADDR !== 16'(m_addr)) begin
                n_fail++;
                $display("FAIL rand_grant@%0d: got valid=%b addr=%0h expected valid=%b addr=%0h", c, bus.VALID, bus.ADDR, m_valid, m_addr);
            end
            n_checks++;
            if (bus.PENDING !== exp_pend || bus.OVERRUN !== m_ovr) begin
                n_fail++;
                $display("FAIL rand_state@%0d: got pend=%0h ovr=%b expected pend=%0h ovr=%b", c, bus.PENDING, bus.OVERRUN, exp_pend, m_ovr);
            end
        end
        bus.REQ     = '0;
        bus.ACK     = 1'b0;
        bus.OVR_CLR = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rr_wrap();
        test_hold();
        test_overrun();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
